test_nios2_0_cpu_mult_ctrl: RTL
===============================

# test_nios2_0_cpu_mult_ctrl

Sequencer that owns the Nios II three-product 16x16 multiplier cell and turns it into a 32x32 multiply unit with a valid/ready request and response interface. It issues one cell pass for low-word results, or two passes for high-word and full 64-bit results. It recombines the partial products and holds the result until the consumer accepts it. It sits between the execute-stage operand muxes and the cell.

## Interface
Parameters:
- CELL_LAT, default 1, cycles from driving `cell_src1`/`cell_src2` with `cell_en`=1 until `cell_p1..p3` show that product. Legal range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  operation code:
  - 00 = low word.
  - 01 = high word unsigned.
  - 10 = full 64-bit unsigned.
  - 11 = high word signed.
- req_a, req_b  in  32  operands.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_lo, rsp_hi  out  32  result words. `rsp_hi` is 0 for op 00.
- flush  in  1  synchronous abort.
- busy  out  1  state is not IDLE.
- cell_src1, cell_src2  out  32  to the cell.
- cell_en  out  1  cell clock enable.
- cell_p1, cell_p2, cell_p3  in  32  cell products:
  - p1 = src1[15:0]*src2[15:0].
  - p2 = src1[15:0]*src2[31:16].
  - p3 = src1[31:16]*src2[15:0].

## Operation
- FSM states: IDLE, RUN, DONE. RUN carries a 3-bit cycle counter `cnt`.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`: latch a, b and op; clear the 64-bit accumulator `acc`; go to RUN with cnt=0.
- RUN, cnt=0: issue pass 1 with `cell_src1`=a, `cell_src2`=b.
- RUN, cnt=1, op≠00: issue pass 2 with `cell_src1`={16'h0,a[31:16]} and `cell_src2`={16'h0,b[31:16]}. Its p1 is a_hi*b_hi; its p2 and p3 are ignored.
- Outside the issue cycles, `cell_src*` hold their last value.
- `cell_en`=1 from cnt=0 through the last product-capture cycle minus one. This is the set of cycles that keeps the cell pipeline advancing.
- Pass-1 capture at cnt=CELL_LAT: acc = p1 + (p2<<16) + (p3<<16), computed to full 64 bits with carries kept.
- Pass-2 capture at cnt=CELL_LAT+1: acc += p1<<32.
- Leave RUN for DONE on the cycle after the last capture:
  - op 00: after pass-1 capture.
  - other ops: after pass-2 capture.
- DONE:
  - `rsp_valid`=1.
  - `rsp_lo`=acc[31:0].
  - `rsp_hi`=acc[63:32], or 0 for op 00.
  - Outputs are stable until `rsp_ready`. Then return to IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake.
- Op 11 signed correction is applied at DONE entry (see Configuration).
- `flush`:
  - In RUN or DONE: go to IDLE next cycle, deassert `rsp_valid`, drop the result, and stop driving `cell_en`.
  - In IDLE: no effect. `flush` has priority over `req_valid` and `rsp_ready`.
- Arithmetic is modulo 2^64. Overflow is never flagged.

## Timing
- Reset values:
  - state=IDLE, so `req_ready`=1, `busy`=0, `rsp_valid`=0.
  - `rsp_lo`, `rsp_hi`, `cell_src1`, `cell_src2`, acc = 0.
  - `cell_en`=0.
- Request handshake in cycle T; cnt=0 in T+1.
- `rsp_valid` first high:
  - op 00: T+2+CELL_LAT. With CELL_LAT=1 that is T+3.
  - other ops: T+3+CELL_LAT. With CELL_LAT=1 that is T+4.
- `req_ready` is combinational from state. `rsp_*` are registered.
- `reset_n` low mid-operation clears everything immediately. No response is emitted after release.
- Same-cycle response handshake and `req_valid`: the request is not accepted that cycle, because `req_ready` is 0 in DONE.

## Configuration
- MULT_CTRL_SIGNED_HI_EN defined:
  - op 11 produces the signed high word: rsp_hi = acc[63:32] − (a[31] ? b : 0) − (b[31] ? a : 0), modulo 2^32.
  - `rsp_lo` is unchanged.
- Undefined: op 11 is treated exactly as op 01 (unsigned high word). No correction logic is built.

## Test plan
- op 00, a=0x0001_0003, b=0x0002_0005, CELL_LAT=1 -> `rsp_valid` at T+3, rsp_lo=0x000B_000F, rsp_hi=0.
- op 10, a=b=0xFFFF_FFFF -> at T+4, rsp_lo=0x0000_0001, rsp_hi=0xFFFF_FFFE. `cell_en` high in exactly T+1 and T+2.
- op 11, a=0xFFFF_FFFF, b=0x0000_0002:
  - with MULT_CTRL_SIGNED_HI_EN -> rsp_hi=0xFFFF_FFFF, rsp_lo=0xFFFF_FFFE.
  - without -> rsp_hi=0x0000_0001.
- op 01 with rsp_ready held low 5 cycles after `rsp_valid`:
  - rsp_lo and rsp_hi stable, `req_ready`=0, a second `req_valid` is ignored.
  - After the handshake, IDLE. Next request is accepted the following cycle.
- `flush` at cnt=1 of an op 10 request -> IDLE next cycle, `rsp_valid` never asserts, `cell_en`=0. An immediate op 00 request 3*5 gives rsp_lo=15.
- `reset_n` pulsed low during RUN -> all outputs at reset values asynchronously. No `rsp_valid` after release. Repeat with CELL_LAT=3 and check `rsp_valid` at T+5 for op 00.

Source files
------------

// File: rtl/test_nios2_0_cpu_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : test_nios2_0_cpu_mult_ctrl
// Brief    : Sequencer that drives the Nios II three-product 16x16 multiplier
//            cell as a 32x32 multiply unit with a valid/ready request and
//            response interface. Low-word ops take one cell pass. High-word
//            and 64-bit ops take two passes.
// Config   : MULT_CTRL_SIGNED_HI_EN - when defined, op 11 returns the signed
//            high word. Otherwise op 11 behaves as op 01.
// Revision : 1.0 - initial release
// ============================================================================
module test_nios2_0_cpu_mult_ctrl #(
    parameter int CELL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [1:0] c_op_lo = 2'b00;
    localparam logic [1:0] c_op_hs = 2'b11;

    // Counter values at which pass-1 and pass-2 products are visible.
    localparam logic [2:0] c_cap1 = 3'(CELL_LAT);
    localparam logic [2:0] c_cap2 = 3'(CELL_LAT + 1);

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_lo;
    logic [31:0] r_rsp_hi;

    logic        w_is_run;
    logic [2:0]  w_last_cnt;
    logic        w_cap1;
    logic        w_cap2;
    logic        w_cap_last;
    logic [63:0] w_pass1;
    logic [63:0] w_acc_next;
    logic [31:0] w_hi_fix;
    logic [31:0] w_rsp_hi_next;

    assign w_is_run   = (r_state == c_st_run);
    assign w_last_cnt = (r_op == c_op_lo) ? c_cap1 : c_cap2;
    assign w_cap1     = w_is_run && (r_cnt == c_cap1);
    assign w_cap2     = w_is_run && (r_op != c_op_lo) && (r_cnt == c_cap2);
    assign w_cap_last = w_is_run && (r_cnt == w_last_cnt);

    // Cross products are each shifted by 16; carries into bit 48+ are kept.
    assign w_pass1 = {32'h0, cell_p1}
                   + {16'h0, cell_p2, 16'h0}
                   + {16'h0, cell_p3, 16'h0};

    // Accumulator update for the current capture cycle (if any).
    always_comb begin
        w_acc_next = r_acc;
        if (w_cap1) begin
            w_acc_next = w_pass1;
        end else if (w_cap2) begin
            w_acc_next = r_acc + {cell_p1, 32'h0};
        end
    end

`ifdef MULT_CTRL_SIGNED_HI_EN
    // Signed high word: subtract the operand-sign correction terms.
    always_comb begin
        w_hi_fix = w_acc_next[63:32];
        if (r_op == c_op_hs) begin
            w_hi_fix = w_acc_next[63:32]
                     - (r_a[31] ? r_b : 32'h0)
                     - (r_b[31] ? r_a : 32'h0);
        end
    end
`else
    assign w_hi_fix = w_acc_next[63:32];
`endif

    assign w_rsp_hi_next = (r_op == c_op_lo) ? 32'h0 : w_hi_fix;

    assign req_ready = (r_state == c_st_idle);
    assign busy      = (r_state != c_st_idle);
    assign cell_en   = w_is_run && (r_cnt < w_last_cnt);
    assign cell_src1 = r_src1;
    assign cell_src2 = r_src2;
    assign rsp_valid = r_rsp_valid;
    assign rsp_lo    = r_rsp_lo;
    assign rsp_hi    = r_rsp_hi;

    // Control FSM, operand latches, cell source registers and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= 3'd0;
            r_op        <= 2'b00;
            r_a         <= 32'h0;
            r_b         <= 32'h0;
            r_acc       <= 64'h0;
            r_src1      <= 32'h0;
            r_src2      <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_lo    <= 32'h0;
            r_rsp_hi    <= 32'h0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_acc   <= 64'h0;
                        r_cnt   <= 3'd0;
                        // Pass-1 sources are on the cell during cnt=0.
                        r_src1  <= req_a;
                        r_src2  <= req_b;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    if (flush) begin
                        r_state     <= c_st_idle;
                        r_rsp_valid <= 1'b0;
                        r_rsp_lo    <= 32'h0;
                        r_rsp_hi    <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                        r_acc <= w_acc_next;
                        // Pass-2 sources (upper halves) are on the cell during cnt=1.
                        if ((r_cnt == 3'd0) && (r_op != c_op_lo)) begin
                            r_src1 <= {16'h0, r_a[31:16]};
                            r_src2 <= {16'h0, r_b[31:16]};
                        end
                        if (w_cap_last) begin
                            r_state     <= c_st_done;
                            r_rsp_valid <= 1'b1;
                            r_rsp_lo    <= w_acc_next[31:0];
                            r_rsp_hi    <= w_rsp_hi_next;
                        end
                    end
                end
                c_st_done: begin
                    if (flush) begin
                        r_state     <= c_st_idle;
                        r_rsp_valid <= 1'b0;
                        r_rsp_lo    <= 32'h0;
                        r_rsp_hi    <= 32'h0;
                    end else if (rsp_ready) begin
                        r_state     <= c_st_idle;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
